// File: rtl/ram_dma_pkg.sv
// Shared types and default sizes for the ram_dma block-copy engine.
package ram_dma_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int RAM_WORDS      = 32'd1 << DEF_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/ram_dma_range_check.sv
// Combinational request qualifier for ram_dma: zero length, range fit, and
// (with DMA_OVERLAP_EN) whether a forward-overlapping copy must run descending.
module ram_dma_range_check
  import ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  in_range,
  output logic                  is_zero
`ifdef DMA_OVERLAP_EN
  ,
  output logic                  descending
`endif
);

  // One extra bit so src+length never wraps, even for the largest length.
  localparam int SUM_WIDTH = LEN_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] LIMIT = {{(SUM_WIDTH-1){1'b0}}, 1'b1} << ADDR_WIDTH;

  logic [SUM_WIDTH-1:0] src_end_s;
  logic [SUM_WIDTH-1:0] dst_end_s;

  // Qualify the request; a copy ending exactly at the top word is legal.
  always_comb begin
    src_end_s = SUM_WIDTH'(src) + SUM_WIDTH'(length);
    dst_end_s = SUM_WIDTH'(dst) + SUM_WIDTH'(length);
    is_zero   = (length == {LEN_WIDTH{1'b0}});
    if ((src_end_s > LIMIT) || (dst_end_s > LIMIT)) begin
      in_range = 1'b0;
    end else begin
      in_range = 1'b1;
    end
`ifdef DMA_OVERLAP_EN
    if ((dst > src) && (SUM_WIDTH'(dst) < src_end_s)) begin
      descending = 1'b1;
    end else begin
      descending = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/ram_dma.sv
// ram_dma: single-port RAM block-copy engine, one READ and one WRITE cycle per word.
// Define DMA_OVERLAP_EN for memmove semantics (descending copy on forward overlap).
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] SrcAddr,
  input  logic [ADDR_WIDTH-1:0] DstAddr,
  input  logic [LEN_WIDTH-1:0]  Length,
  input  logic                  Abort,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                state_r;
  logic [ADDR_WIDTH-1:0] src_ptr_r;
  logic [ADDR_WIDTH-1:0] dst_ptr_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  desc_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;
  logic                  mem_write_r;

  logic                  in_range_s;
  logic                  is_zero_s;
  logic                  desc_s;
  logic [ADDR_WIDTH-1:0] span_s;
  logic [ADDR_WIDTH-1:0] first_src_s;
  logic [ADDR_WIDTH-1:0] first_dst_s;
  logic [ADDR_WIDTH-1:0] next_src_s;
  logic [ADDR_WIDTH-1:0] next_dst_s;

  ram_dma_range_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_range_check (
    .src        (SrcAddr),
    .dst        (DstAddr),
    .length     (Length),
    .in_range   (in_range_s),
    .is_zero    (is_zero_s)
`ifdef DMA_OVERLAP_EN
    ,
    .descending (desc_s)
`endif
  );

`ifdef DMA_OVERLAP_EN
`else
  assign desc_s = 1'b0;
`endif

  // Start pointers (last word of each range when descending) and per-word step.
  always_comb begin
    span_s = Length[ADDR_WIDTH-1:0] - ADDR_ONE;
    if (desc_s) begin
      first_src_s = SrcAddr + span_s;
      first_dst_s = DstAddr + span_s;
    end else begin
      first_src_s = SrcAddr;
      first_dst_s = DstAddr;
    end
    if (desc_r) begin
      next_src_s = src_ptr_r - ADDR_ONE;
      next_dst_s = dst_ptr_r - ADDR_ONE;
    end else begin
      next_src_s = src_ptr_r + ADDR_ONE;
      next_dst_s = dst_ptr_r + ADDR_ONE;
    end
  end

  // Copy sequencer; every RAM-side output is prepared one cycle ahead.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      src_ptr_r   <= ADDR_ZERO;
      dst_ptr_r   <= ADDR_ZERO;
      mem_addr_r  <= ADDR_ZERO;
      remaining_r <= LEN_ZERO;
      data_r      <= DATA_ZERO;
      desc_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            if (is_zero_s) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else if (!in_range_s) begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end else begin
              state_r     <= ST_READ;
              src_ptr_r   <= first_src_s;
              dst_ptr_r   <= first_dst_s;
              remaining_r <= Length;
              desc_r      <= desc_s;
              busy_r      <= 1'b1;
              mem_addr_r  <= first_src_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (Abort) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            mem_addr_r <= ADDR_ZERO;
          end else begin
            state_r     <= ST_WRITE;
            data_r      <= MemReadData;
            mem_addr_r  <= dst_ptr_r;
            mem_write_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          mem_write_r <= 1'b0;
          data_r      <= DATA_ZERO;
          if (Abort) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            mem_addr_r <= ADDR_ZERO;
          end else begin
            src_ptr_r   <= next_src_s;
            dst_ptr_r   <= next_dst_s;
            remaining_r <= remaining_r - LEN_ONE;
            if (remaining_r == LEN_ONE) begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              busy_r     <= 1'b0;
              mem_addr_r <= ADDR_ZERO;
            end else begin
              state_r    <= ST_READ;
              mem_addr_r <= next_src_s;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        ST_ERR: begin
          state_r <= ST_IDLE;
          error_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_addr_r  <= ADDR_ZERO;
          data_r      <= DATA_ZERO;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          error_r     <= 1'b0;
          mem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy         = busy_r;
  assign Done         = done_r;
  assign Error        = error_r;
  assign MemAddress   = mem_addr_r;
  assign MemWriteData = data_r;
  // A write presented while Reset is high must not reach the RAM.
  assign MemWrite     = mem_write_r & ~Reset;

endmodule

// File: tb/tb_ram_dma.sv
// Randomized bench for ram_dma: behavioural RAM plus a word-level copy model.
module tb_ram_dma;
  import ram_dma_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int LW = AW + 1;
  localparam int NW = RAM_WORDS;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          Clock = 1'b0;
  logic          Reset, Start, Abort;
  logic [AW-1:0] SrcAddr, DstAddr;
  logic [LW-1:0] Length;
  logic          Busy, Done, Error, MemWrite;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData, MemReadData;

  logic [DW-1:0] ram     [NW];
  logic [DW-1:0] ref_mem [NW];
  wr_t           wlog [$];
  int            cyc = 0;
  logic          init_en, pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] pat [4];

  ram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Length(Length), .Abort(Abort), .Busy(Busy), .Done(Done), .Error(Error),
    .MemAddress(MemAddress), .MemWrite(MemWrite), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign MemReadData = ram[MemAddress];

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (init_en) begin
      for (int i = 0; i < NW; i++) ram[i] <= seed_word(i);
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (MemWrite) begin
      ram[MemAddress] <= MemWriteData;
      wlog.push_back('{c: cyc, a: MemAddress, d: MemWriteData});
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge Clock);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge Clock); #1;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // ka/kr/sk: cycle (relative to the Start cycle) of Abort / Reset / a stray Start; 0 = none.
  task automatic run(input string tag, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                     input logic [LW-1:0] len, input int ka, input int kr, input int sk);
    int  n, c0, win, wbase, cut, exp_busy, exp_done, exp_err;
    int  busy_n, done_n, done_k, err_n, err_k, diffs, nexp, ngot;
    bit  acc, desc;
    wr_t exp_q [$];
    n = int'(len);
    desc = 1'b0;
    acc = (n != 0) && (int'(src) + n <= NW) && (int'(dst) + n <= NW);
`ifdef DMA_OVERLAP_EN
    desc = (dst > src) && (int'(dst) < int'(src) + n);
`endif
    if (!acc) begin ka = 0; kr = 0; sk = 0; end
    exp_busy = 0; exp_done = 0; exp_err = 0;
    if (n == 0) exp_done = 1;
    else if (!acc) exp_err = 1;
    else begin
      cut = 0;
      if (ka >= 1 && ka <= 2 * n) cut = ka;
      if (kr >= 1 && kr <= 2 * n) cut = kr;
      exp_busy = (cut != 0) ? cut : 2 * n;
      exp_done = (cut != 0) ? 0 : 2 * n + 1;
      for (int i = 0; i < n; i++) begin
        int off, wc;
        off = desc ? (n - 1 - i) : i;
        wc = 2 * i + 2;
        if ((kr != 0 && wc >= kr) || (ka != 0 && wc > ka)) break;
        ref_mem[int'(dst) + off] = ref_mem[int'(src) + off];
        exp_q.push_back('{c: wc, a: AW'(int'(dst) + off), d: ref_mem[int'(dst) + off]});
      end
    end
    win = acc ? 2 * n + 3 : 3;
    busy_n = 0; done_n = 0; done_k = 0; err_n = 0; err_k = 0;
    wbase = wlog.size();
    @(negedge Clock);
    c0 = cyc;
    SrcAddr = src; DstAddr = dst; Length = len; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    SrcAddr = AW'($urandom); DstAddr = AW'($urandom); Length = LW'($urandom);
    for (int k = 1; k <= win; k++) begin
      @(negedge Clock);
      if (Busy) busy_n++;
      if (Done) begin done_n++; if (done_k == 0) done_k = k; end
      if (Error) begin err_n++; if (err_k == 0) err_k = k; end
      if (kr != 0 && k == kr + 1)
        check_eq({tag, "_rst_out"}, 64'({Busy, Done, Error, MemWrite, MemAddress, MemWriteData}), 64'd0);
      Abort = (k == ka);
      Reset = (k == kr);
      if (k == sk) begin
        Start = 1'b1; SrcAddr = AW'($urandom); DstAddr = AW'($urandom);
        Length = LW'($urandom_range(1, 8));
      end
      @(posedge Clock); #1;
      Abort = 1'b0; Reset = 1'b0; Start = 1'b0;
    end
    check_eq({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
    check_eq({tag, "_done_n"}, 64'(done_n), 64'((exp_done != 0) ? 1 : 0));
    check_eq({tag, "_done_at"}, 64'(done_k), 64'(exp_done));
    check_eq({tag, "_err_n"}, 64'(err_n), 64'(exp_err));
    check_eq({tag, "_err_at"}, 64'(err_k), 64'(exp_err));
    nexp = exp_q.size();
    ngot = wlog.size() - wbase;
    check_eq({tag, "_nwr"}, 64'(ngot), 64'(nexp));
    for (int j = 0; j < nexp && j < ngot; j++)
      check_eq($sformatf("%s_wr%0d", tag, j),
               64'({16'(wlog[wbase + j].c - c0), wlog[wbase + j].a, wlog[wbase + j].d}),
               64'({16'(exp_q[j].c), exp_q[j].a, exp_q[j].d}));
    diffs = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== ref_mem[i]) diffs++;
    check_eq({tag, "_mem"}, 64'(diffs), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] s, d;
    logic [LW-1:0] l;
    int            ka, kr, sk;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0;
    init_en = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < NW; i++) ref_mem[i] = seed_word(i);
    repeat (3) @(posedge Clock);
    #1;
    init_en = 1'b0; Reset = 1'b0;
    @(negedge Clock);
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_done", 64'(Done), 64'd0);
    check_eq("rst_error", 64'(Error), 64'd0);
    check_eq("rst_mwrite", 64'(MemWrite), 64'd0);
    check_eq("rst_maddr", 64'(MemAddress), 64'd0);
    check_eq("rst_mwdata", 64'(MemWriteData), 64'd0);

    pat[0] = 32'hCAFE_000A; pat[1] = 32'hCAFE_000B; pat[2] = 32'hCAFE_000C; pat[3] = 32'hCAFE_000D;
    for (int i = 0; i < 4; i++) preload(AW'(32'h10 + i), pat[i]);
    run("len4", 14'h0010, 14'h0100, 15'd4, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("len4_dst%0d", i), 64'(ram[32'h100 + i]), 64'(pat[i]));

    run("len0", 14'h0200, 14'h0300, 15'd0, 0, 0, 0);
    run("src_oob", 14'h3FFE, 14'h0000, 15'd4, 0, 0, 0);
    run("dst_top", 14'h0040, 14'h3FFC, 15'd4, 0, 0, 0);
    run("dst_oob", 14'h0040, 14'h3FFD, 15'd4, 0, 0, 0);
    run("len_max", 14'h0000, 14'h0000, 15'h7FFF, 0, 0, 0);
    run("rst_mid", 14'h0050, 14'h0150, 15'd4, 0, 4, 0);
    run("stray_start", 14'h0060, 14'h0160, 15'd4, 0, 0, 2);
    run("abort", 14'h0070, 14'h0170, 15'd4, 3, 0, 0);

    for (int i = 0; i < 4; i++) preload(AW'(32'h20 + i), 32'(i + 1));
    run("overlap", 14'h0020, 14'h0022, 15'd4, 0, 0, 0);
`ifdef DMA_OVERLAP_EN
    pat[0] = 32'd1; pat[1] = 32'd2; pat[2] = 32'd3; pat[3] = 32'd4;
`else
    pat[0] = 32'd1; pat[1] = 32'd2; pat[2] = 32'd1; pat[3] = 32'd2;
`endif
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("overlap_dst%0d", i), 64'(ram[32'h22 + i]), 64'(pat[i]));

    for (int r = 0; r < 24; r++) begin
      s = AW'($urandom); d = AW'($urandom); l = LW'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
        0: s = AW'(NW - $urandom_range(1, 10));
        1: d = AW'(NW - $urandom_range(1, 10));
        2: d = s + AW'($urandom_range(0, 4));
        3: s = d + AW'($urandom_range(0, 4));
        default: ;
      endcase
      ka = 0; kr = 0; sk = 0;
      if (l != '0) begin
        case ($urandom_range(0, 5))
          0: ka = $urandom_range(1, 2 * int'(l));
          1: kr = $urandom_range(1, 2 * int'(l));
          2: sk = $urandom_range(1, 2 * int'(l));
          default: ;
        endcase
      end
      run($sformatf("rnd%0d", r), s, d, l, ka, kr, sk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-copy engine that acts as the initiator on the single-port RAM interface (Address / MemWrite / WriteData / ReadData). On a Start pulse it copies Length 32-bit words from SrcAddr to DstAddr, one word at a time, then pulses Done. It sits between the control logic and the RAM port, and it owns that port while Busy.

## Interface
Parameters:
- ADDR_WIDTH, 14, RAM word-address width (RAM holds 2^ADDR_WIDTH words).
- DATA_WIDTH, 32, word width.
- LEN_WIDTH, ADDR_WIDTH+1, Length width, so a full-RAM copy is representable.

Ports:
- Clock, input, 1, single clock; all state changes on the rising edge.
- Reset, input, 1, synchronous, active-high.
- Start, input, 1, request; sampled only in IDLE.
- SrcAddr, input, ADDR_WIDTH, first source word; sampled with Start.
- DstAddr, input, ADDR_WIDTH, first destination word; sampled with Start.
- Length, input, LEN_WIDTH, word count; sampled with Start.
- Abort, input, 1, cancels an active copy.
- Busy, output, 1, high from the cycle after an accepted Start through the last WRITE cycle.
- Done, output, 1, one-cycle pulse on successful completion.
- Error, output, 1, one-cycle pulse when a request is rejected.
- MemAddress, output, ADDR_WIDTH, drives the RAM Address input.
- MemWrite, output, 1, drives RAM MemWrite.
- MemWriteData, output, DATA_WIDTH, drives RAM WriteData.
- MemReadData, input, DATA_WIDTH, from RAM ReadData (combinational read).

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE, Start=1, range check:
  - Length==0 goes to DONE.
  - Out-of-range goes to ERR. Out-of-range means SrcAddr+Length > 2^ADDR_WIDTH or DstAddr+Length > 2^ADDR_WIDTH, computed at LEN_WIDTH+1 bits with no wrap. A request ending exactly at the top word is legal.
  - Otherwise the engine latches the pointers and remaining=Length, then goes to READ.
- READ: MemAddress=src_ptr and MemWrite=0. At the edge, data_reg<=MemReadData and the state goes to WRITE.
- WRITE: MemAddress=dst_ptr, MemWrite=1, MemWriteData=data_reg. At the edge, the pointers step by 1 and remaining decrements.
  - remaining==1 goes to DONE.
  - Otherwise the state goes back to READ.
- DONE: Done=1 for one cycle, then IDLE.
- ERR: Error=1 for one cycle, then IDLE. No RAM access happens.
- Start outside IDLE is ignored. There is no queueing.
- Abort in READ or WRITE goes to IDLE at the next edge, with no Done and no Error.
  - A write presented in the abort cycle still commits, because the RAM writes on that edge.
  - Abort in IDLE, DONE or ERR has no effect.
- Reset wins over Abort and Start.
- Reset mid-copy goes to IDLE at the next edge. The write presented in that cycle is suppressed (MemWrite is forced to 0 while Reset=1).
- MemAddress=0 and MemWriteData=0 in IDLE, DONE and ERR. MemWrite=1 only in WRITE.

## Timing
- Reset values: Busy=0, Done=0, Error=0, MemWrite=0, MemAddress=0, MemWriteData=0, state=IDLE.
- Start accepted at edge T. The first READ occupies cycle T+1.
- N words take 2N cycles (T+1 .. T+2N). Done is high in cycle T+2N+1. A new Start is accepted in cycle T+2N+2 or later.
- Length==0: Done in cycle T+1. Error reject: Error in cycle T+1.
- Busy=1 exactly in READ and WRITE.
- Word i is written in cycle T+2i+2 (i from 0).
- Each READ is a single cycle and relies on the RAM's combinational read, so no wait states exist.

## Configuration
- DMA_OVERLAP_EN defined: memmove semantics.
  - If DstAddr > SrcAddr and DstAddr < SrcAddr+Length, the engine copies descending. It starts at src+Length-1 and dst+Length-1, and the pointers decrement.
  - All other requests copy ascending.
  - Cycle counts are unchanged.
- DMA_OVERLAP_EN undefined: always ascending. A forward overlapping copy replicates source data; this is documented, not an error.

## Structure
- Package ram_dma_pkg: the state enum, the ADDR_WIDTH/DATA_WIDTH defaults, and the RAM_WORDS constant (2^ADDR_WIDTH).
- One sub-module, ram_dma_range_check: combinational. It takes Src, Dst and Length, and outputs in_range, is_zero, and (under DMA_OVERLAP_EN) descending.
- The FSM, pointers and data_reg live in ram_dma.

## Test plan
- Src=0x0010, Dst=0x0100, Len=4, RAM[0x10..0x13]=A,B,C,D -> 4 WRITE cycles at T+2,4,6,8. Done at T+9. RAM[0x100..0x103]=A,B,C,D. Busy high for 8 cycles.
- Len=0 -> Done at T+1, MemWrite never 1. Len=4 with Src=0x3FFE -> Error at T+1, no writes, Busy stays 0.
- Dst=0x3FFC, Len=4 -> accepted, last write to 0x3FFF, Done. Dst=0x3FFD, Len=4 -> Error.
- Reset asserted at T+4 (second WRITE) -> only Dst+0 written, all outputs zero at T+5. Start at T+2 during Busy -> ignored. Abort at T+3 -> one word written, no Done.
- With DMA_OVERLAP_EN: Src=0x20, Dst=0x22, Len=4, data 1,2,3,4 -> RAM[0x22..0x25]=1,2,3,4, first write to 0x25.
- Without DMA_OVERLAP_EN: same stimulus -> RAM[0x22..0x25]=1,2,1,2.
